pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four stall/flush sources into per-stage register enables and flushes:
  - data-memory wait
  - multi-cycle mul/div in EX
  - EX-stage redirect (taken branch or jump)
  - ID load-use hazard
- Holds the multi-cycle wait FSM, a mul/div watchdog and saturating performance counters.
- Sits beside the hazard-detection logic and drives every pipeline-register enable/flush and the PC enable.

Parameters:
- MD_TIMEOUT, 64: maximum MD_WAIT cycles before the watchdog fires.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_use_in  in  1  load-use hazard detected in ID.
- redirect_in  in  1  EX resolved a taken branch or jump; PC mux selects the target.
- md_start_in  in  1  mul/div instruction valid in EX, operation not yet done.
- md_done_in  in  1  mul/div result valid this cycle.
- dmem_wait_in  in  1  data memory not ready for the MEM-stage access.
- pc_en  out  1  PC register update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline-register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a NOP bubble (flush wins over enable).
- md_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.
- flush_events  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- FSM states: RUN=2'd0, MD_WAIT=2'd1, MEM_WAIT=2'd2.
  - Registered; 2'd3 is illegal and recovers to RUN.
- Reset (rst_n=0, asynchronous): state=RUN, md counter=0, md_timeout=0, both perf counters=0.
  - While rst_n=0, combinational outputs are forced: all *_en=0, all *_flush=1.
- Enables and flushes are combinational from state and inputs (zero-latency stall). State and counters update on the clk rising edge.
- Default (RUN, no event): all enables=1, all flushes=0.
- RUN priority, highest first:
  1. dmem_wait_in=1: all enables=0, no flush; next=MEM_WAIT.
  2. md_start_in=1 and md_done_in=0:
     - pc_en, if_id_en, id_ex_en = 0.
     - ex_mem_flush=1, mem_wb_en=1 (WB drains).
     - next=MD_WAIT; md counter=1.
  3. redirect_in=1: all enables=1, if_id_flush=1, id_ex_flush=1; flush_events+1.
     - Any load_use_in in the same cycle is ignored, because the ID instruction is squashed.
  4. load_use_in=1:
     - pc_en=0, if_id_en=0, id_ex_flush=1.
     - ex_mem_en=1, mem_wb_en=1.
- md_start_in with md_done_in=1 in the same RUN cycle is single-cycle: no stall, the RUN priority list continues at rule 3.
- MEM_WAIT:
  - While dmem_wait_in=1: all enables=0.
  - On the first cycle with dmem_wait_in=0: outputs are evaluated with RUN rules 2–4 in that same cycle, and the next state follows those rules (RUN or MD_WAIT).
  - Frozen EX/ID contents keep redirect and hazard inputs stable, so no event is lost.
- MD_WAIT:
  - Outputs as RUN rule 2 each cycle; md counter +1 per cycle.
  - On md_done_in=1: outputs are evaluated with RUN rules 3–4 (result captured into EX/MEM); next=RUN.
  - dmem_wait_in=1 in MD_WAIT: all enables=0, the md counter still advances, state stays MD_WAIT.
- Watchdog: when the md counter reaches MD_TIMEOUT in MD_WAIT without md_done_in:
  - md_timeout is set and stays set until reset.
  - next=RUN; the instruction proceeds with an undefined result.
- stall_cycles increments on every post-reset cycle with pc_en=0.
- Both counters saturate at all-ones and never wrap.
- Asynchronous reset mid-MD_WAIT or mid-MEM_WAIT aborts immediately to RUN with counters cleared.

Test Plan:
- Reset, then idle 5 cycles -> all enables=1, flushes=0, stall_cycles=0, state=RUN.
- load_use_in=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles=1; the next cycle is normal.
- redirect_in=1 together with load_use_in=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events=1; stall_cycles unchanged.
- md_start_in=1, md_done_in after 4 cycles -> pc_en=0 and ex_mem_flush=1 for 4 cycles; done cycle has ex_mem_en=1, ex_mem_flush=0; stall_cycles=4; back in RUN.
- dmem_wait_in=1 for 3 cycles entered from MD_WAIT, then md_done_in -> all enables=0 for the 3 wait cycles; the md counter keeps advancing; clean return to RUN.
- md_start_in held with no md_done_in, MD_TIMEOUT=8 -> md_timeout=1 after 8 cycles and stays set; state=RUN. Assert rst_n=0 mid-wait on a rerun -> state=RUN and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Purpose : central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
// Latency : enables/flushes are combinational from state and inputs (zero-latency stall);
//           state, watchdog and counters update on the clk rising edge.
// Backpr. : dmem wait freezes every stage; mul/div wait freezes IF/ID/EX and drains WB.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   load_use_in           ID load-use hazard
//   redirect_in           EX taken branch/jump
//   md_start_in           mul/div valid in EX and not yet done
//   md_done_in            mul/div result valid this cycle
//   dmem_wait_in          data memory not ready for the MEM-stage access
//   pc_en, *_en           PC and pipeline-register enables
//   *_flush               load a NOP bubble (flush wins over enable)
//   md_timeout            sticky mul/div watchdog error
//   stall_cycles          saturating count of cycles with pc_en=0
//   flush_events          saturating count of accepted redirects
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_in,
  input  logic             redirect_in,
  input  logic             md_start_in,
  input  logic             md_done_in,
  input  logic             dmem_wait_in,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int MDC_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [MDC_W-1:0] MD_LIMIT = MDC_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // One bundle for all stage controls so each rule is a single constant.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctl_t;

  // A flushed register is also enabled: the flush loads the bubble.
  localparam ctl_t CTL_RUN    = 8'b11111_000;
  localparam ctl_t CTL_FREEZE = 8'b00000_000;
  localparam ctl_t CTL_MD     = 8'b00011_001;  // hold IF/ID/EX, bubble into MEM, WB drains
  localparam ctl_t CTL_REDIR  = 8'b11111_110;  // squash the two wrong-path instructions
  localparam ctl_t CTL_LU     = 8'b00111_010;  // hold PC/IF-ID, bubble into EX
  localparam ctl_t CTL_RESET  = 8'b00000_111;

  state_e             state_q, state_d;
  logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
  logic               md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  ctl_t ctl;
  ctl_t ctl_out;
  logic md_stall;
  logic eval_r2;      // evaluate the RUN list from the mul/div rule down
  logic eval_r34;     // evaluate only redirect / load-use
  logic redirect_acc;

  assign md_stall = md_start_in && !md_done_in;

  always_comb begin
    ctl          = CTL_RUN;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    eval_r2      = 1'b0;
    eval_r34     = 1'b0;
    redirect_acc = 1'b0;

    case (state_q)
      MD_WAIT: begin
        if (dmem_wait_in) begin
          // Memory stall freezes everything but the mul/div keeps running.
          ctl = CTL_FREEZE;
          if (md_cnt_q < MD_LIMIT) md_cnt_d = md_cnt_q + 1'b1;
        end else if (md_done_in || (md_cnt_q >= MD_LIMIT)) begin
          // Done, or watchdog forces the instruction out with a garbage result.
          if (!md_done_in) md_timeout_d = 1'b1;
          eval_r34 = 1'b1;
          state_d  = RUN;
          md_cnt_d = '0;
        end else begin
          ctl      = CTL_MD;
          md_cnt_d = md_cnt_q + 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_wait_in) begin
          ctl = CTL_FREEZE;
        end else begin
          eval_r2 = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        // RUN, and recovery from the unused encoding.
        if (dmem_wait_in) begin
          ctl     = CTL_FREEZE;
          state_d = MEM_WAIT;
        end else begin
          eval_r2 = 1'b1;
          state_d = RUN;
        end
      end
    endcase

    if (eval_r2 && md_stall) begin
      ctl      = CTL_MD;
      state_d  = MD_WAIT;
      md_cnt_d = MDC_W'(1);
    end else if (eval_r2 || eval_r34) begin
      // Redirect outranks load-use: the hazarding ID instruction is squashed.
      if (redirect_in) begin
        ctl          = CTL_REDIR;
        redirect_acc = 1'b1;
      end else if (load_use_in) begin
        ctl = CTL_LU;
      end
    end

    stall_d = stall_q;
    if (!ctl.pc_en && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    flush_d = flush_q;
    if (redirect_acc && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  // Reset holds every register and bubbles every stage, independent of the clock.
  assign ctl_out = rst_n ? ctl : CTL_RESET;

  assign pc_en        = ctl_out.pc_en;
  assign if_id_en     = ctl_out.if_id_en;
  assign id_ex_en     = ctl_out.id_ex_en;
  assign ex_mem_en    = ctl_out.ex_mem_en;
  assign mem_wb_en    = ctl_out.mem_wb_en;
  assign if_id_flush  = ctl_out.if_id_flush;
  assign id_ex_flush  = ctl_out.id_ex_flush;
  assign ex_mem_flush = ctl_out.ex_mem_flush;
  assign md_timeout   = md_timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose : self-checking bench for pipeline_ctrl (directed vectors + per-cycle model).
// Latency : inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Backpr. : n/a.
module tb_pipeline_ctrl;

  localparam int MD_TO = 8;
  localparam int CW    = 6;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_use_in, redirect_in, md_start_in, md_done_in, dmem_wait_in;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic          md_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  int total  = 0;
  int passed = 0;

  pipeline_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_in(load_use_in), .redirect_in(redirect_in),
    .md_start_in(md_start_in), .md_done_in(md_done_in), .dmem_wait_in(dmem_wait_in),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  wire [4:0] ens = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [2:0] fls = {if_id_flush, id_ex_flush, ex_mem_flush};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a pending mul/div is just an age; a memory wait needs no state of its
  // own because leaving it is indistinguishable from an ordinary running cycle.
  // Stage controls are expressed as "how many leading stages hold" plus a bubble mask.
  int m_age = 0;
  bit m_to  = 0;
  int m_stall = 0;
  int m_flush = 0;

  always @(negedge clk) begin
    int       hold, n_age, n_stall, n_flush;
    bit       n_to, redir;
    logic [2:0] bub;
    logic [4:0] exp_en;
    if (!rst_n) begin
      m_age = 0; m_to = 0; m_stall = 0; m_flush = 0;
      chk("cyc_rst_en", ens, 5'b00000);
      chk("cyc_rst_flush", fls, 3'b111);
      chk("cyc_rst_stall", stall_cycles, 0);
      chk("cyc_rst_flushcnt", flush_events, 0);
      chk("cyc_rst_timeout", md_timeout, 0);
    end else begin
      hold = 0; bub = 3'b000; redir = 0; n_age = m_age; n_to = m_to;
      if (dmem_wait_in) begin
        hold = 5;
        if (m_age > 0 && m_age < MD_TO) n_age = m_age + 1;
      end else if (m_age > 0 && !md_done_in && m_age < MD_TO) begin
        hold = 3; bub = 3'b001; n_age = m_age + 1;
      end else if (m_age == 0 && md_start_in && !md_done_in) begin
        hold = 3; bub = 3'b001; n_age = 1;
      end else begin
        if (m_age > 0 && !md_done_in) n_to = 1;
        n_age = 0;
        if (redirect_in) begin bub = 3'b110; redir = 1; end
        else if (load_use_in) begin hold = 2; bub = 3'b010; end
      end
      for (int i = 0; i < 5; i++) exp_en[4-i] = (i >= hold);
      chk("cyc_en", ens, exp_en);
      chk("cyc_flush", fls, bub);
      chk("cyc_stall", stall_cycles, m_stall);
      chk("cyc_flushcnt", flush_events, m_flush);
      chk("cyc_timeout", md_timeout, m_to);
      n_stall = (hold >= 1 && m_stall < SAT) ? m_stall + 1 : m_stall;
      n_flush = (redir && m_flush < SAT) ? m_flush + 1 : m_flush;
      m_age = n_age; m_to = n_to; m_stall = n_stall; m_flush = n_flush;
    end
  end

  task automatic step(input logic lu, input logic rd, input logic ms, input logic md, input logic dw);
    @(posedge clk);
    #1;
    load_use_in = lu; redirect_in = rd; md_start_in = ms; md_done_in = md; dmem_wait_in = dw;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    load_use_in = 0; redirect_in = 0; md_start_in = 0; md_done_in = 0; dmem_wait_in = 0;
    step(0,0,0,0,0); step(0,0,0,0,0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_flushes", fls, 3'b111);
    chk("rst_stall", stall_cycles, 0);

    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) step(0,0,0,0,0);
    chk("idle_en", ens, 5'b11111);
    chk("idle_flush", fls, 3'b000);
    chk("idle_stall", stall_cycles, 0);

    // load-use bubble
    step(1,0,0,0,0);
    chk("lu_ctl", {pc_en, if_id_en, id_ex_flush, ex_mem_en, mem_wb_en}, 5'b00111);
    step(0,0,0,0,0);
    chk("lu_stall", stall_cycles, 1);
    chk("lu_after_pc", pc_en, 1);

    // redirect overrides load-use
    step(1,1,0,0,0);
    chk("redir_ctl", {if_id_flush, id_ex_flush, pc_en}, 3'b111);
    step(0,0,0,0,0);
    chk("redir_cnt", flush_events, 1);
    chk("redir_stall", stall_cycles, 1);

    // 4-cycle mul/div
    for (int i = 0; i < 4; i++) begin
      step(0,0,1,0,0);
      chk($sformatf("md_wait%0d", i), {pc_en, ex_mem_flush}, 2'b01);
    end
    step(0,0,1,1,0);
    chk("md_done_ctl", {ex_mem_en, ex_mem_flush, pc_en}, 3'b101);
    step(0,0,0,0,0);
    chk("md_stall", stall_cycles, 5);

    // mul/div interrupted by a memory wait
    step(0,0,1,0,0); step(0,0,1,0,0);
    for (int i = 0; i < 3; i++) begin
      step(0,0,1,0,1);
      chk($sformatf("mdmem_en%0d", i), ens, 5'b00000);
    end
    step(0,0,1,1,0);
    chk("mdmem_done_pc", pc_en, 1);
    step(0,0,0,0,0);
    chk("mdmem_stall", stall_cycles, 10);
    chk("mdmem_to", md_timeout, 0);

    // memory wait from RUN, redirect on release
    step(0,0,0,0,1); step(0,0,0,0,1);
    chk("mem_freeze", {ens, fls}, 8'b00000_000);
    step(0,1,0,0,0);
    chk("mem_exit_redir", {pc_en, if_id_flush}, 2'b11);
    step(0,0,0,0,0);
    chk("mem_exit_stall", stall_cycles, 12);
    chk("mem_exit_cnt", flush_events, 2);

    // memory wait released into a mul/div stall
    step(0,0,1,0,1);
    step(0,0,1,0,0);
    chk("mem2md", {pc_en, ex_mem_flush}, 2'b01);
    step(0,0,1,1,0); step(0,0,0,0,0);
    chk("mem2md_stall", stall_cycles, 14);

    // watchdog: 8 stall cycles, then forced release
    repeat (8) step(0,0,1,0,0);
    chk("wd_pre", md_timeout, 0);
    step(0,0,1,0,0);
    chk("wd_fire_pc", pc_en, 1);
    step(0,0,0,0,0);
    chk("wd_sticky", md_timeout, 1);
    chk("wd_stall", stall_cycles, 22);
    repeat (3) step(0,0,0,0,0);
    chk("wd_hold", md_timeout, 1);
    chk("wd_run", ens, 5'b11111);

    // asynchronous reset in the middle of a mul/div wait
    step(0,0,1,0,0); step(0,0,1,0,0); step(0,0,1,0,0);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("arst_stall", stall_cycles, 0);
    chk("arst_to", md_timeout, 0);
    chk("arst_cnt", flush_events, 0);
    chk("arst_ctl", {ens, fls}, 8'b00000_111);
    md_start_in = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    step(0,0,0,0,0);
    chk("arst_run", ens, 5'b11111);

    // watchdog age keeps counting through a memory wait
    step(0,0,1,0,0); step(0,0,1,0,0); step(0,0,1,0,0);
    repeat (5) step(0,0,1,0,1);
    step(0,0,1,0,0);
    chk("wdmem_fire_pc", pc_en, 1);
    step(0,0,0,0,0);
    chk("wdmem_to", md_timeout, 1);
    chk("wdmem_stall", stall_cycles, 8);

    // saturation of both counters
    repeat (70) step(1,0,0,0,0);
    step(0,0,0,0,0);
    chk("sat_stall", stall_cycles, SAT);
    repeat (70) step(0,1,0,0,0);
    step(0,0,0,0,0);
    chk("sat_flush", flush_events, SAT);
    chk("sat_stall_hold", stall_cycles, SAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
